// File: rtl/e203_icb_splt_pkg.sv
// ---------------------------------------------------------------------------
// e203_icb_splt_pkg
// Shared definitions for the ICB 1:N splitter:
//   - fixed ICB sideband field widths (burst / beat / size)
//   - upper bound on the number of downstream ports the encoder handles
//   - one-hot to binary port-ID encoder; an all-zero select maps to the
//     local error slot, whose ID equals the number of ports
// ---------------------------------------------------------------------------
package e203_icb_splt_pkg;

    localparam int ICB_BURST_W  = 2;
    localparam int ICB_BEAT_W   = 2;
    localparam int ICB_SIZE_W   = 2;
    localparam int ICB_SPLT_MAX = 32;

    // Returns the index of the set bit in 'oh'.
    // An all-zero select returns 'n', the local error slot ID.
    function automatic int onehot_enc(input logic [ICB_SPLT_MAX-1:0] oh, input int n);
        int id;
        id = n;
        for (int k = ICB_SPLT_MAX - 1; k >= 0; k--) begin
            if (oh[k]) id = k;
        end
        return id;
    endfunction

endpackage

// File: rtl/e203_icb_splt_idfifo.sv
// ---------------------------------------------------------------------------
// e203_icb_splt_idfifo
// Small synchronous FIFO holding the port ID of every outstanding command.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes FIFO)
//   i_vld/i_rdy/i_dat push side; i_rdy = not full, with no pop pass-through
//   o_vld/o_rdy/o_dat pop side;  o_vld = not empty, o_dat = head entry
// ---------------------------------------------------------------------------
module e203_icb_splt_idfifo #(
    parameter int DP = 2,
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);

    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = $clog2(DP + 1);

    logic [DW-1:0] r_mem [DP];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign i_rdy  = (r_cnt != CW'(DP));
    assign o_vld  = (r_cnt != '0);
    assign o_dat  = r_mem[r_rptr];
    assign w_push = i_vld & i_rdy;
    assign w_pop  = o_vld & o_rdy;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PW'(DP - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PW'(DP - 1)) ? '0 : r_rptr + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/e203_icb_splt.sv
// ---------------------------------------------------------------------------
// e203_icb_splt
// ICB 1:N splitter. Each upstream command goes to the downstream port named
// by the one-hot i_icb_splt_indic; responses return upstream strictly in
// command order, taken only from the port at the head of the ID FIFO.
// An all-zero select is answered locally with an error response.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_icb_splt_indic            one-hot target select, sampled with the cmd
//   i_icb_cmd_* / i_icb_rsp_*   upstream ICB command / response channel
//   o_bus_icb_cmd_*             per-port command channel (fields replicated)
//   o_bus_icb_rsp_*             per-port response channel
// Handshake rule: a transfer happens on a channel in every cycle where both
// valid and ready are high; valid never depends on ready of the same
// channel, and ready may depend on valid.
// ---------------------------------------------------------------------------
module e203_icb_splt
    import e203_icb_splt_pkg::*;
#(
    parameter int AW               = 32,
    parameter int DW               = 32,
    parameter int USR_W            = 1,
    parameter int SPLT_NUM         = 4,
    parameter int SPLT_PTR_W       = 3,
    parameter int FIFO_OUTS_NUM    = 2,
    parameter int ALLOW_0CYCLE_RSP = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SPLT_NUM-1:0]           i_icb_splt_indic,

    input  logic                          i_icb_cmd_valid,
    output logic                          i_icb_cmd_ready,
    input  logic                          i_icb_cmd_read,
    input  logic [AW-1:0]                 i_icb_cmd_addr,
    input  logic [DW-1:0]                 i_icb_cmd_wdata,
    input  logic [DW/8-1:0]               i_icb_cmd_wmask,
    input  logic [ICB_BURST_W-1:0]        i_icb_cmd_burst,
    input  logic [ICB_BEAT_W-1:0]         i_icb_cmd_beat,
    input  logic                          i_icb_cmd_lock,
    input  logic                          i_icb_cmd_excl,
    input  logic [ICB_SIZE_W-1:0]         i_icb_cmd_size,
    input  logic [USR_W-1:0]              i_icb_cmd_usr,

    output logic                          i_icb_rsp_valid,
    input  logic                          i_icb_rsp_ready,
    output logic                          i_icb_rsp_err,
    output logic                          i_icb_rsp_excl_ok,
    output logic [DW-1:0]                 i_icb_rsp_rdata,
    output logic [USR_W-1:0]              i_icb_rsp_usr,

    output logic [SPLT_NUM-1:0]             o_bus_icb_cmd_valid,
    input  logic [SPLT_NUM-1:0]             o_bus_icb_cmd_ready,
    output logic [SPLT_NUM-1:0]             o_bus_icb_cmd_read,
    output logic [SPLT_NUM*AW-1:0]          o_bus_icb_cmd_addr,
    output logic [SPLT_NUM*DW-1:0]          o_bus_icb_cmd_wdata,
    output logic [SPLT_NUM*(DW/8)-1:0]      o_bus_icb_cmd_wmask,
    output logic [SPLT_NUM*ICB_BURST_W-1:0] o_bus_icb_cmd_burst,
    output logic [SPLT_NUM*ICB_BEAT_W-1:0]  o_bus_icb_cmd_beat,
    output logic [SPLT_NUM-1:0]             o_bus_icb_cmd_lock,
    output logic [SPLT_NUM-1:0]             o_bus_icb_cmd_excl,
    output logic [SPLT_NUM*ICB_SIZE_W-1:0]  o_bus_icb_cmd_size,
    output logic [SPLT_NUM*USR_W-1:0]       o_bus_icb_cmd_usr,

    input  logic [SPLT_NUM-1:0]             o_bus_icb_rsp_valid,
    output logic [SPLT_NUM-1:0]             o_bus_icb_rsp_ready,
    input  logic [SPLT_NUM-1:0]             o_bus_icb_rsp_err,
    input  logic [SPLT_NUM-1:0]             o_bus_icb_rsp_excl_ok,
    input  logic [SPLT_NUM*DW-1:0]          o_bus_icb_rsp_rdata,
    input  logic [SPLT_NUM*USR_W-1:0]       o_bus_icb_rsp_usr
);

    localparam logic [SPLT_PTR_W-1:0] LOCAL_ERR_ID = SPLT_PTR_W'(SPLT_NUM);

    logic                  w_fifo_i_rdy;
    logic                  w_fifo_o_vld;
    logic [SPLT_PTR_W-1:0] w_fifo_o_dat;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_no_indic;
    logic                  w_cmd_hsk;
    logic                  w_rsp_hsk;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [SPLT_PTR_W-1:0] w_cmd_id;
    logic                  w_head_vld;
    logic [SPLT_PTR_W-1:0] w_head_id;

    assign w_full     = ~w_fifo_i_rdy;
    assign w_empty    = ~w_fifo_o_vld;
    assign w_no_indic = (i_icb_splt_indic == '0);
    assign w_cmd_id   = SPLT_PTR_W'(onehot_enc(ICB_SPLT_MAX'(i_icb_splt_indic), SPLT_NUM));

    // Command fan-out: zero latency, no command register.
    assign o_bus_icb_cmd_valid = {SPLT_NUM{i_icb_cmd_valid & ~w_full}} & i_icb_splt_indic;
    assign i_icb_cmd_ready     = ~w_full & ((|(i_icb_splt_indic & o_bus_icb_cmd_ready)) | w_no_indic);
    assign w_cmd_hsk           = i_icb_cmd_valid & i_icb_cmd_ready;

    assign o_bus_icb_cmd_read  = {SPLT_NUM{i_icb_cmd_read}};
    assign o_bus_icb_cmd_addr  = {SPLT_NUM{i_icb_cmd_addr}};
    assign o_bus_icb_cmd_wdata = {SPLT_NUM{i_icb_cmd_wdata}};
    assign o_bus_icb_cmd_wmask = {SPLT_NUM{i_icb_cmd_wmask}};
    assign o_bus_icb_cmd_burst = {SPLT_NUM{i_icb_cmd_burst}};
    assign o_bus_icb_cmd_beat  = {SPLT_NUM{i_icb_cmd_beat}};
    assign o_bus_icb_cmd_lock  = {SPLT_NUM{i_icb_cmd_lock}};
    assign o_bus_icb_cmd_excl  = {SPLT_NUM{i_icb_cmd_excl}};
    assign o_bus_icb_cmd_size  = {SPLT_NUM{i_icb_cmd_size}};
    assign o_bus_icb_cmd_usr   = {SPLT_NUM{i_icb_cmd_usr}};

    // Head selection: the oldest outstanding ID, or, with an empty FIFO and
    // zero-cycle responses allowed, the command being accepted right now.
    always_comb begin
        w_head_vld = 1'b0;
        w_head_id  = w_fifo_o_dat;
        if (!w_empty) begin
            w_head_vld = 1'b1;
        end else if ((ALLOW_0CYCLE_RSP != 0) && w_cmd_hsk) begin
            w_head_vld = 1'b1;
            w_head_id  = w_cmd_id;
        end
    end

    // Response mux: only the head port may hand a response upstream.
    always_comb begin
        i_icb_rsp_valid     = 1'b0;
        i_icb_rsp_err       = 1'b0;
        i_icb_rsp_excl_ok   = 1'b0;
        i_icb_rsp_rdata     = '0;
        i_icb_rsp_usr       = '0;
        o_bus_icb_rsp_ready = '0;
        if (w_head_vld) begin
            if (w_head_id == LOCAL_ERR_ID) begin
                i_icb_rsp_valid = 1'b1;
                i_icb_rsp_err   = 1'b1;
            end else begin
                for (int k = 0; k < SPLT_NUM; k++) begin
                    if (w_head_id == SPLT_PTR_W'(k)) begin
                        i_icb_rsp_valid        = o_bus_icb_rsp_valid[k];
                        i_icb_rsp_err          = o_bus_icb_rsp_err[k];
                        i_icb_rsp_excl_ok      = o_bus_icb_rsp_excl_ok[k];
                        i_icb_rsp_rdata        = o_bus_icb_rsp_rdata[k*DW +: DW];
                        i_icb_rsp_usr          = o_bus_icb_rsp_usr[k*USR_W +: USR_W];
                        o_bus_icb_rsp_ready[k] = i_icb_rsp_ready;
                    end
                end
            end
        end
    end

    assign w_rsp_hsk = i_icb_rsp_valid & i_icb_rsp_ready;
    // A command answered in its own cycle never enters the FIFO.
    assign w_bypass  = w_empty & w_cmd_hsk & w_rsp_hsk;
    assign w_push    = w_cmd_hsk & ~w_bypass;
    assign w_pop     = w_rsp_hsk & ~w_empty;

    e203_icb_splt_idfifo #(
        .DP (FIFO_OUTS_NUM),
        .DW (SPLT_PTR_W)
    ) u_idfifo (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_push),
        .i_rdy (w_fifo_i_rdy),
        .i_dat (w_cmd_id),
        .o_vld (w_fifo_o_vld),
        .o_rdy (w_pop),
        .o_dat (w_fifo_o_dat)
    );

    a_indic_onehot0: assert property (@(posedge clk) disable iff (rst)
        i_icb_cmd_valid |-> $onehot0(i_icb_splt_indic));

endmodule

// File: tb/tb_e203_icb_splt.sv
module tb_e203_icb_splt;
    import e203_icb_splt_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int UW = 1;
    localparam int N  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N-1:0]             indic;
    logic                     cmd_valid, cmd_ready, cmd_read, cmd_lock, cmd_excl;
    logic [AW-1:0]            cmd_addr;
    logic [DW-1:0]            cmd_wdata;
    logic [DW/8-1:0]          cmd_wmask;
    logic [1:0]               cmd_burst, cmd_beat, cmd_size;
    logic [UW-1:0]            cmd_usr;
    logic                     rsp_valid, rsp_ready, rsp_err, rsp_excl_ok;
    logic [DW-1:0]            rsp_rdata;
    logic [UW-1:0]            rsp_usr;
    logic [N-1:0]             b_cmd_valid, b_cmd_ready, b_cmd_read, b_cmd_lock, b_cmd_excl;
    logic [N*AW-1:0]          b_cmd_addr;
    logic [N*DW-1:0]          b_cmd_wdata;
    logic [N*(DW/8)-1:0]      b_cmd_wmask;
    logic [N*2-1:0]           b_cmd_burst, b_cmd_beat, b_cmd_size;
    logic [N*UW-1:0]          b_cmd_usr;
    logic [N-1:0]             b_rsp_valid, b_rsp_ready, b_rsp_err, b_rsp_excl_ok;
    logic [N*DW-1:0]          b_rsp_rdata;
    logic [N*UW-1:0]          b_rsp_usr;

    e203_icb_splt dut (
        .clk(clk), .rst(rst), .i_icb_splt_indic(indic),
        .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready), .i_icb_cmd_read(cmd_read),
        .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
        .i_icb_cmd_burst(cmd_burst), .i_icb_cmd_beat(cmd_beat), .i_icb_cmd_lock(cmd_lock),
        .i_icb_cmd_excl(cmd_excl), .i_icb_cmd_size(cmd_size), .i_icb_cmd_usr(cmd_usr),
        .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_err(rsp_err),
        .i_icb_rsp_excl_ok(rsp_excl_ok), .i_icb_rsp_rdata(rsp_rdata), .i_icb_rsp_usr(rsp_usr),
        .o_bus_icb_cmd_valid(b_cmd_valid), .o_bus_icb_cmd_ready(b_cmd_ready),
        .o_bus_icb_cmd_read(b_cmd_read), .o_bus_icb_cmd_addr(b_cmd_addr),
        .o_bus_icb_cmd_wdata(b_cmd_wdata), .o_bus_icb_cmd_wmask(b_cmd_wmask),
        .o_bus_icb_cmd_burst(b_cmd_burst), .o_bus_icb_cmd_beat(b_cmd_beat),
        .o_bus_icb_cmd_lock(b_cmd_lock), .o_bus_icb_cmd_excl(b_cmd_excl),
        .o_bus_icb_cmd_size(b_cmd_size), .o_bus_icb_cmd_usr(b_cmd_usr),
        .o_bus_icb_rsp_valid(b_rsp_valid), .o_bus_icb_rsp_ready(b_rsp_ready),
        .o_bus_icb_rsp_err(b_rsp_err), .o_bus_icb_rsp_excl_ok(b_rsp_excl_ok),
        .o_bus_icb_rsp_rdata(b_rsp_rdata), .o_bus_icb_rsp_usr(b_rsp_usr)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] indic;
        logic         cmd_valid;
        logic [N-1:0] b_cmd_ready;
        logic [N-1:0] b_rsp_valid;
        logic         rsp_ready;
        logic         e_cmd_ready;
        logic [N-1:0] e_b_cmd_valid;
        logic         e_rsp_valid;
        logic [N-1:0] e_b_rsp_ready;
        logic         e_rsp_err;
        logic [DW-1:0] e_rsp_rdata;
        logic [1:0]   e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [N-1:0] ind, input logic cv, input logic [N-1:0] bcr,
                                input logic [N-1:0] brv, input logic rr, input logic ecr,
                                input logic [N-1:0] ebcv, input logic erv, input logic [N-1:0] ebrr,
                                input logic eerr, input logic [DW-1:0] erd, input logic [1:0] ecnt);
        vec_t v;
        v.indic = ind; v.cmd_valid = cv; v.b_cmd_ready = bcr; v.b_rsp_valid = brv; v.rsp_ready = rr;
        v.e_cmd_ready = ecr; v.e_b_cmd_valid = ebcv; v.e_rsp_valid = erv; v.e_b_rsp_ready = ebrr;
        v.e_rsp_err = eerr; v.e_rsp_rdata = erd; v.e_cnt = ecnt;
        return v;
    endfunction

    // Drive one cycle, check combinational outputs mid-cycle, then the FIFO
    // count just after the active edge.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        indic       = v.indic;
        cmd_valid   = v.cmd_valid;
        b_cmd_ready = v.b_cmd_ready;
        b_rsp_valid = v.b_rsp_valid;
        rsp_ready   = v.rsp_ready;
        #3;
        chk({tag, ".cmd_ready"},     64'(cmd_ready),   64'(v.e_cmd_ready));
        chk({tag, ".bus_cmd_valid"}, 64'(b_cmd_valid), 64'(v.e_b_cmd_valid));
        chk({tag, ".rsp_valid"},     64'(rsp_valid),   64'(v.e_rsp_valid));
        chk({tag, ".bus_rsp_ready"}, 64'(b_rsp_ready), 64'(v.e_b_rsp_ready));
        if (v.e_rsp_valid) begin
            chk({tag, ".rsp_err"},   64'(rsp_err),   64'(v.e_rsp_err));
            chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.e_rsp_rdata));
        end
        @(posedge clk);
        #1;
        chk({tag, ".fifo_cnt"}, 64'(dut.u_idfifo.r_cnt), 64'(v.e_cnt));
    endtask

    task automatic idle_inputs();
        indic = '0; cmd_valid = 1'b0; b_cmd_ready = '0; b_rsp_valid = '0; rsp_ready = 1'b0;
    endtask

    initial begin
        // Static command fields and per-port response data.
        cmd_read = 1'b1; cmd_addr = 32'h0000_1000; cmd_wdata = 32'hDEAD_BEEF; cmd_wmask = 4'hF;
        cmd_burst = 2'd0; cmd_beat = 2'd0; cmd_lock = 1'b0; cmd_excl = 1'b0; cmd_size = 2'd2;
        cmd_usr = '0;
        b_rsp_rdata   = {32'h0000_3333, 32'h0000_A5A5, 32'h0000_2222, 32'h0000_1111};
        b_rsp_err     = 4'b1000;
        b_rsp_excl_ok = 4'b0000;
        b_rsp_usr     = '0;
        idle_inputs();

        //          indic  cv bcr    brv    rr | cr ebcv   erv ebrr   err rdata          cnt
        // reset / idle
        vecs.push_back(mk(4'b0010, 0, 4'b0010, 4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 0, 32'h0, 2'd0));
        // routing to port 2, response next cycle
        vecs.push_back(mk(4'b0100, 1, 4'b0100, 4'b0000, 1, 1, 4'b0100, 0, 4'b0100, 0, 32'h0, 2'd1));
        vecs.push_back(mk(4'b0100, 0, 4'b0000, 4'b0100, 1, 0, 4'b0000, 1, 4'b0100, 0, 32'h0000_A5A5, 2'd0));
        // ordering: port0 then port3, port3 answers first and is held
        vecs.push_back(mk(4'b0001, 1, 4'b0001, 4'b0000, 0, 1, 4'b0001, 0, 4'b0000, 0, 32'h0, 2'd1));
        vecs.push_back(mk(4'b1000, 1, 4'b1000, 4'b1000, 1, 1, 4'b1000, 0, 4'b0001, 0, 32'h0, 2'd2));
        // full: third cmd waits, even on the cycle the head pops
        vecs.push_back(mk(4'b0010, 1, 4'b0010, 4'b1000, 1, 0, 4'b0000, 0, 4'b0001, 0, 32'h0, 2'd2));
        vecs.push_back(mk(4'b0010, 1, 4'b0010, 4'b1001, 1, 0, 4'b0000, 1, 4'b0001, 0, 32'h0000_1111, 2'd1));
        // third cmd accepted while port3 pops (push+pop)
        vecs.push_back(mk(4'b0010, 1, 4'b0010, 4'b1000, 1, 1, 4'b0010, 1, 4'b1000, 1, 32'h0000_3333, 2'd1));
        vecs.push_back(mk(4'b0010, 0, 4'b0010, 4'b0010, 1, 1, 4'b0000, 1, 4'b0010, 0, 32'h0000_2222, 2'd0));
        // zero-cycle: cmd and rsp on port1 in the same cycle
        vecs.push_back(mk(4'b0010, 1, 4'b0010, 4'b0010, 1, 1, 4'b0010, 1, 4'b0010, 0, 32'h0000_2222, 2'd0));
        // decode error: no select
        vecs.push_back(mk(4'b0000, 1, 4'b1111, 4'b0000, 0, 1, 4'b0000, 1, 4'b0000, 1, 32'h0, 2'd1));
        vecs.push_back(mk(4'b0000, 0, 4'b1111, 4'b1111, 1, 1, 4'b0000, 1, 4'b0000, 1, 32'h0, 2'd0));
        // empty: stray downstream responses are held off
        vecs.push_back(mk(4'b0000, 0, 4'b0000, 4'b1111, 1, 1, 4'b0000, 0, 4'b0000, 0, 32'h0, 2'd0));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.fifo_cnt", 64'(dut.u_idfifo.r_cnt), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 1) begin
                // address replicated to the selected port
                indic = 4'b0100; cmd_valid = 1'b1;
                #1;
                chk("route.addr_p2", 64'(b_cmd_addr[2*AW +: AW]), 64'h1000);
            end
            apply(vecs[i], i);
        end

        // Reset with two commands outstanding flushes the FIFO.
        indic = 4'b0001; cmd_valid = 1'b1; b_cmd_ready = 4'b1111; b_rsp_valid = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        indic = 4'b0100;
        @(posedge clk); #1;
        chk("rstmid.cnt_before", 64'(dut.u_idfifo.r_cnt), 64'd2);
        idle_inputs();
        #1;
        chk("rstmid.cmd_ready_full", 64'(cmd_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        b_rsp_valid = 4'b1111; rsp_ready = 1'b1;
        #1;
        chk("rstmid.cnt_after", 64'(dut.u_idfifo.r_cnt), 64'd0);
        chk("rstmid.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid.bus_rsp_ready", 64'(b_rsp_ready), 64'd0);
        chk("rstmid.cmd_ready", 64'(cmd_ready), 64'd1);
        idle_inputs();
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
